load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the RV32I core. Consumes the effective address computed by the execute-stage ALU, together with the store data and funct3 of the instruction in flight. Drives a word-addressed request/grant/rvalid data bus, stalls the pipeline while an access is outstanding, and returns sign- or zero-extended load data to writeback. Misaligned accesses and illegal funct3 raise an exception instead of reaching the bus.

## Interface
- BUS_TIMEOUT, 255: cycles spent in WAIT_RSP without rvalid before the access is aborted (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  a valid instruction is present in execute.
- ex_is_load  in  1  the instruction is a load.
- ex_is_store  in  1  the instruction is a store.
- ex_funct3  in  3  access size and sign.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- ex_addr  in  32  effective byte address (ALU result).
- ex_wdata  in  32  store data (rs2).
- ex_rd  in  5  load destination register.
- stall  out  1  freeze upstream pipeline stages.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word-aligned address.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  lane-aligned write data.
- dbus_gnt  in  1  request accepted.
- dbus_rvalid  in  1  read data valid.
- dbus_rdata  in  32  read data.
- wb_valid  out  1  one-cycle pulse: load result ready.
- wb_rd  out  5  load destination register.
- wb_data  out  32  extended load result.
- misalign_exc  out  1  one-cycle pulse: misaligned address or illegal funct3.
- bus_err  out  1  one-cycle pulse: response timeout.
- fault_addr  out  32  ex_addr of the last faulting access.

## Operation
- States: IDLE, REQ, WAIT_RSP.
- An operation is offered when ex_valid is high and ex_is_load or ex_is_store is high. If both are high, the load takes priority.
- IDLE with an offered, aligned, legal operation:
  - Latch the address, byte enables, lane data, rd, funct3 and the read/write flag.
  - Go to REQ.
- IDLE with an offered operation that is misaligned or has illegal funct3:
  - No bus access.
  - Next cycle: misalign_exc = 1 and fault_addr = ex_addr.
  - Stay in IDLE.
- Misalignment rules:
  - Halfword access with addr[0] set.
  - Word access with addr[1:0] nonzero.
- REQ:
  - dbus_req = 1 while in REQ; all dbus outputs come from registers and stay stable until grant.
  - On gnt for a store, go to IDLE.
  - On gnt for a load, go to WAIT_RSP.
- WAIT_RSP:
  - On rvalid, register wb_data, wb_rd and wb_valid = 1, and go to IDLE.
- Address and lanes:
  - dbus_addr = {addr[31:2], 2'b00}.
  - SB: be = 1 << addr[1:0], byte replicated to all four lanes.
  - SH: be = 0011 or 1100, halfword replicated to both halves.
  - SW: be = 1111.
  - Loads use the same byte enables. The selected byte or halfword of rdata is sign-extended (LB, LH) or zero-extended (LBU, LHU).
- stall = (state != IDLE) OR (state == IDLE AND an aligned, legal operation is offered). A misaligned operation does not stall.
- rvalid or gnt arriving while in IDLE is ignored.

## Timing
- Reset values: state IDLE; every output 0, including dbus_* outputs, wb_*, misalign_exc, bus_err and fault_addr.
- A reset mid-access abandons the access; a late response after reset is ignored.
- Zero-wait bus, operation accepted in cycle N:
  - dbus_req is high in N+1 and gnt arrives in N+1.
  - Store: stall is low in N+2.
  - Load: rvalid arrives in N+2; stall is low and wb_valid is high in N+3.
- Every gnt wait cycle and every rvalid wait cycle adds one cycle of stall.
- Back-to-back operations: the earliest acceptance of the next operation is the cycle in which stall drops.
- wb_valid, misalign_exc and bus_err are single-cycle registered pulses.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT_RSP.
  - When it reaches BUS_TIMEOUT without rvalid: bus_err pulses, fault_addr is latched, no wb_valid is produced, and the state returns to IDLE.
- LSU_TIMEOUT_EN undefined: WAIT_RSP waits indefinitely; bus_err is tied to 0.

## Test plan
- LW at 0x100 on a zero-wait bus, rdata = 0xDEADBEEF -> dbus_addr 0x100, be 1111, wb_data 0xDEADBEEF, wb_valid in N+3, stall high in N and N+1–N+2, low in N+3.
- LB at 0x203 and LBU at 0x203, rdata = 0x80112233 -> wb_data 0xFFFFFF80 and 0x00000080 respectively, be 1000.
- SH at 0x302, ex_wdata 0x0000ABCD, gnt delayed 3 cycles -> be 1100, wdata 0xABCDABCD, dbus_req and outputs stable for 4 cycles, stall low in the cycle after gnt.
- LW at 0x101 -> no dbus_req, misalign_exc pulses in N+1, fault_addr 0x101, stall never high.
- Load granted, reset asserted in WAIT_RSP, then a stale rvalid -> all outputs 0 immediately, no wb_valid.
- With LSU_TIMEOUT_EN and BUS_TIMEOUT = 4, load granted and no rvalid -> bus_err pulses after 4 WAIT_RSP cycles, state returns to IDLE, stall drops.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit; define LSU_TIMEOUT_EN to abort loads after BUS_TIMEOUT idle cycles.
// Latency: zero-wait store frees the pipe 2 cycles after acceptance, load returns wb_valid 3 cycles after.
// Backpressure: stall holds upstream while an access is accepted or outstanding; gnt/rvalid waits extend it.
module load_store_unit #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } req_t;

`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  state_t      state_q, state_d;
  req_t        req_q, new_req;
  logic [7:0]  tmo_cnt;
  logic        offered, legal, misaligned, accept, fault, timeout;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode the offered operation; a load wins when both flags are set.
  always_comb begin
    offered = ex_valid & (ex_is_load | ex_is_store);
    if (ex_is_load)
      legal = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      legal = ex_funct3 inside {3'b000, 3'b001, 3'b010};
    case (ex_funct3[1:0])
      2'b01:   misaligned = ex_addr[0];
      2'b10:   misaligned = |ex_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    new_req.we     = ~ex_is_load;
    new_req.addr   = ex_addr;
    new_req.rd     = ex_rd;
    new_req.funct3 = ex_funct3;
    case (ex_funct3[1:0])
      2'b00: begin
        new_req.be    = 4'b0001 << ex_addr[1:0];
        new_req.wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        new_req.be    = ex_addr[1] ? 4'b1100 : 4'b0011;
        new_req.wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        new_req.be    = 4'b1111;
        new_req.wdata = ex_wdata;
      end
    endcase
    accept = (state_q == IDLE) & offered & legal & ~misaligned;
    fault  = (state_q == IDLE) & offered & ~(legal & ~misaligned);
  end

  // Lane select and extension of the returned word.
  always_comb begin
    case (req_q.addr[1:0])
      2'b00:   ld_byte = dbus_rdata[7:0];
      2'b01:   ld_byte = dbus_rdata[15:8];
      2'b10:   ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = req_q.addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (req_q.funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dbus_rdata;
    endcase
  end

  assign timeout = TMO_EN && (state_q == WAIT_RSP) && !dbus_rvalid && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = accept;
        if (accept) state_d = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (dbus_gnt) state_d = req_q.we ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (dbus_rvalid || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= '0;
      dbus_req     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      fault_addr   <= '0;
      tmo_cnt      <= '0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      if (accept) begin
        req_q    <= new_req;
        dbus_req <= 1'b1;
      end
      if (state_q == REQ && dbus_gnt) dbus_req <= 1'b0;
      if (fault) begin
        misalign_exc <= 1'b1;
        fault_addr   <= ex_addr;
      end
      if (state_q == WAIT_RSP && dbus_rvalid) begin
        wb_valid <= 1'b1;
        wb_rd    <= req_q.rd;
        wb_data  <= ld_data;
      end
      if (timeout) begin
        bus_err    <= 1'b1;
        fault_addr <= req_q.addr;
      end
      // Counter restarts every time the FSM passes through REQ.
      if (state_q == REQ)           tmo_cnt <= '0;
      else if (state_q == WAIT_RSP) tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign dbus_we    = req_q.we;
  assign dbus_addr  = {req_q.addr[31:2], 2'b00};
  assign dbus_be    = req_q.be;
  assign dbus_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs change 1ns after the rising edge, outputs sampled 2ns after it.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_exc, bus_err;
  logic [31:0] fault_addr;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .stall(stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign_exc(misalign_exc),
    .bus_err(bus_err), .fault_addr(fault_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'b000; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_ex();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    step(); step();
    tests++; if ({stall, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata} !== '0) begin fails++; $display("FAIL reset_bus got %h exp 0", {stall, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata}); end
    tests++; if ({wb_valid, wb_rd, wb_data, misalign_exc, bus_err, fault_addr} !== '0) begin fails++; $display("FAIL reset_wb got %h exp 0", {wb_valid, wb_rd, wb_data, misalign_exc, bus_err, fault_addr}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw();
    offer(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3);
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lw_stall_n got %b exp 1", stall); end
    step(); clear_ex(); dbus_gnt = 1'b1; #1;
    tests++; if ({dbus_req, dbus_we, dbus_addr, dbus_be, stall} !== {1'b1, 1'b0, 32'h100, 4'b1111, 1'b1}) begin fails++; $display("FAIL lw_req got %h exp %h", {dbus_req, dbus_we, dbus_addr, dbus_be, stall}, {1'b1, 1'b0, 32'h100, 4'b1111, 1'b1}); end
    step(); dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hDEADBEEF; #1;
    tests++; if ({dbus_req, stall, wb_valid} !== 3'b010) begin fails++; $display("FAIL lw_n2 got %b exp 010", {dbus_req, stall, wb_valid}); end
    step(); dbus_rvalid = 1'b0; #1;
    tests++; if ({wb_valid, wb_rd, wb_data, stall} !== {1'b1, 5'd3, 32'hDEADBEEF, 1'b0}) begin fails++; $display("FAIL lw_wb got %h exp %h", {wb_valid, wb_rd, wb_data, stall}, {1'b1, 5'd3, 32'hDEADBEEF, 1'b0}); end
    step();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL lw_pulse got %b exp 0", wb_valid); end
  endtask

  task automatic test_byte_loads();
    logic [2:0]  f3s [2]  = '{3'b000, 3'b100};
    logic [31:0] exps [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 1'b0, f3s[i], 32'h203, 32'h0, 5'd9);
      step(); clear_ex(); dbus_gnt = 1'b1; #1;
      tests++; if ({dbus_addr, dbus_be} !== {32'h200, 4'b1000}) begin fails++; $display("FAIL lb_be[%0d] got %h exp %h", i, {dbus_addr, dbus_be}, {32'h200, 4'b1000}); end
      step(); dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h80112233;
      step(); dbus_rvalid = 1'b0; #1;
      tests++; if ({wb_valid, wb_data} !== {1'b1, exps[i]}) begin fails++; $display("FAIL lb_data[%0d] got %h exp %h", i, {wb_valid, wb_data}, {1'b1, exps[i]}); end
      step();
    end
  endtask

  task automatic test_sh_gnt_wait();
    offer(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000ABCD, 5'd0);
    step(); clear_ex();
    for (int c = 0; c < 4; c++) begin
      dbus_gnt = (c == 3); #1;
      tests++; if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall} !== {1'b1, 1'b1, 32'h300, 4'b1100, 32'hABCDABCD, 1'b1}) begin fails++; $display("FAIL sh_hold[%0d] got %h exp %h", c, {dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall}, {1'b1, 1'b1, 32'h300, 4'b1100, 32'hABCDABCD, 1'b1}); end
      step();
    end
    dbus_gnt = 1'b0; #1;
    tests++; if ({dbus_req, stall} !== 2'b00) begin fails++; $display("FAIL sh_done got %b exp 00", {dbus_req, stall}); end
    step();
  endtask

  task automatic test_misalign();
    offer(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd1);
    tests++; if ({stall, dbus_req} !== 2'b00) begin fails++; $display("FAIL mis_n got %b exp 00", {stall, dbus_req}); end
    step(); clear_ex(); #1;
    tests++; if ({misalign_exc, fault_addr, stall, dbus_req} !== {1'b1, 32'h101, 2'b00}) begin fails++; $display("FAIL mis_exc got %h exp %h", {misalign_exc, fault_addr, stall, dbus_req}, {1'b1, 32'h101, 2'b00}); end
    step();
    tests++; if ({misalign_exc, dbus_req} !== 2'b00) begin fails++; $display("FAIL mis_pulse got %b exp 00", {misalign_exc, dbus_req}); end
    offer(1'b0, 1'b1, 3'b100, 32'h240, 32'h0, 5'd0);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL illegal_st_stall got %b exp 0", stall); end
    step(); clear_ex(); #1;
    tests++; if ({misalign_exc, fault_addr, dbus_req} !== {1'b1, 32'h240, 1'b0}) begin fails++; $display("FAIL illegal_st got %h exp %h", {misalign_exc, fault_addr, dbus_req}, {1'b1, 32'h240, 1'b0}); end
    offer(1'b0, 1'b1, 3'b001, 32'h281, 32'h0, 5'd0);
    step(); clear_ex(); #1;
    tests++; if ({misalign_exc, fault_addr, dbus_req} !== {1'b1, 32'h281, 1'b0}) begin fails++; $display("FAIL mis_sh got %h exp %h", {misalign_exc, fault_addr, dbus_req}, {1'b1, 32'h281, 1'b0}); end
    step();
  endtask

  task automatic test_back_to_back();
    offer(1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 5'd0);
    step(); clear_ex(); dbus_gnt = 1'b1; #1;
    tests++; if ({dbus_we, dbus_addr, dbus_be, dbus_wdata} !== {1'b1, 32'h400, 4'b1111, 32'h12345678}) begin fails++; $display("FAIL b2b_sw got %h exp %h", {dbus_we, dbus_addr, dbus_be, dbus_wdata}, {1'b1, 32'h400, 4'b1111, 32'h12345678}); end
    step(); dbus_gnt = 1'b0;
    offer(1'b1, 1'b1, 3'b001, 32'h402, 32'h0, 5'd21);
    tests++; if ({stall, dbus_req} !== 2'b10) begin fails++; $display("FAIL b2b_accept got %b exp 10", {stall, dbus_req}); end
    step(); clear_ex(); dbus_gnt = 1'b1; #1;
    tests++; if ({dbus_req, dbus_we, dbus_addr, dbus_be} !== {1'b1, 1'b0, 32'h400, 4'b1100}) begin fails++; $display("FAIL b2b_lh_req got %h exp %h", {dbus_req, dbus_we, dbus_addr, dbus_be}, {1'b1, 1'b0, 32'h400, 4'b1100}); end
    step(); dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h80017FFF;
    step(); dbus_rvalid = 1'b0; #1;
    tests++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd21, 32'hFFFF8001}) begin fails++; $display("FAIL b2b_lh_wb got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd21, 32'hFFFF8001}); end
    step();
  endtask

  task automatic test_reset_mid();
    offer(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd7);
    step(); clear_ex(); dbus_gnt = 1'b1;
    step(); dbus_gnt = 1'b0;
    rst = 1'b1; #1;
    tests++; if ({stall, dbus_req, dbus_addr, dbus_be, wb_valid, fault_addr} !== '0) begin fails++; $display("FAIL rst_mid got %h exp 0", {stall, dbus_req, dbus_addr, dbus_be, wb_valid, fault_addr}); end
    step(); rst = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h11111111;
    step(); dbus_rvalid = 1'b0; #1;
    tests++; if ({wb_valid, wb_data, stall, dbus_req} !== '0) begin fails++; $display("FAIL rst_stale got %h exp 0", {wb_valid, wb_data, stall, dbus_req}); end
    step();
  endtask

  task automatic test_timeout();
    offer(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd4);
    step(); clear_ex(); dbus_gnt = 1'b1;
    step(); dbus_gnt = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tests++; if ({stall, bus_err} !== 2'b10) begin fails++; $display("FAIL tmo_wait[%0d] got %b exp 10", c, {stall, bus_err}); end
      step();
    end
    tests++; if ({bus_err, fault_addr, stall, wb_valid} !== {1'b1, 32'h600, 2'b00}) begin fails++; $display("FAIL tmo_err got %h exp %h", {bus_err, fault_addr, stall, wb_valid}, {1'b1, 32'h600, 2'b00}); end
    step();
    tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL tmo_pulse got %b exp 0", bus_err); end
`else
    for (int c = 0; c < 10; c++) begin
      tests++; if ({stall, bus_err} !== 2'b10) begin fails++; $display("FAIL notmo_wait[%0d] got %b exp 10", c, {stall, bus_err}); end
      step();
    end
    dbus_rvalid = 1'b1; dbus_rdata = 32'h0BADF00D;
    step(); dbus_rvalid = 1'b0; #1;
    tests++; if ({wb_valid, wb_data, stall} !== {1'b1, 32'h0BADF00D, 1'b0}) begin fails++; $display("FAIL notmo_wb got %h exp %h", {wb_valid, wb_data, stall}, {1'b1, 32'h0BADF00D, 1'b0}); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_sh_gnt_wait();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
